adc_serial_reader: RTL and testbench
====================================

Name: adc_serial_reader

Overview:
Serial front-end for the external 12-bit ADC. Periodically runs one 16-clock read frame over a 3-wire SPI-style link (CS_n, SCLK, SDATA) and delivers the parallel `ADC[11:0]` word with a one-cycle valid strobe. Its output feeds the ADC comparator stage in the PLL loop. The block is gated by `swiptAlive` in the same way as the rest of the loop.

Parameters:
- CLK_DIV, 4, `clk` cycles per SCLK half-period; legal range 2..255.
- SAMPLE_PERIOD, 200, `clk` cycles between conversion-start opportunities; legal range 2..65535.
- LEAD_BITS, 4, leading zero bits preceding the 12 data bits. Frame length FRAME = LEAD_BITS+12.

Ports:
- clk  in  1  system clock
- nrst  in  1  reset
- swiptAlive  in  1  link-alive enable; low acts as a synchronous abort
- adc_sdata  in  1  serial data from the ADC, MSB first
- adc_cs_n  out  1  ADC chip select, active-low
- adc_sclk  out  1  serial clock, idles high (CPOL=1)
- ADC  out  12  last good sample
- adc_valid  out  1  one-cycle pulse when `ADC` updates
- busy  out  1  high while a frame is in progress (state != IDLE)
- overrun  out  1  one-cycle pulse when a period expires while busy
- frame_err  out  1  one-cycle pulse on a leading-bit violation (macro builds only; tied 0 otherwise)

Behaviour:
- Reset: `nrst` is synchronous, active-low; clock is `clk`.
- Reset values:
  - `adc_cs_n`=1, `adc_sclk`=1, `ADC`=0.
  - `adc_valid`, `busy`, `overrun`, `frame_err` = 0.
  - Period counter = SAMPLE_PERIOD-1; FSM = IDLE.
- `swiptAlive`=0 acts identically to reset on the next edge, including mid-frame:
  - CS_n and SCLK are forced high.
  - `ADC` is cleared to 0.
  - No `adc_valid` is issued.
- Period counter:
  - Free-running down-counter. At 0 it reloads SAMPLE_PERIOD-1.
  - At 0 with FSM in IDLE: issue start.
  - At 0 with FSM not in IDLE: pulse `overrun`, no start; the frame in progress is unaffected.
- FSM states: IDLE -> SETUP -> SHIFT -> QUIET -> IDLE.
- IDLE:
  - CS_n=1, SCLK=1.
  - On start: CS_n<=0 on the same edge; go to SETUP.
- SETUP:
  - Hold CS_n low and SCLK high for CLK_DIV cycles, then go to SHIFT.
- SHIFT:
  - SCLK toggles every CLK_DIV cycles. The first toggle is a falling edge.
  - Each bit is a low phase then a high phase (2*CLK_DIV cycles).
  - `adc_sdata` is shifted into a FRAME-bit register on the `clk` edge that drives SCLK 0->1. No synchronizer; data settled CLK_DIV cycles earlier.
  - Bit counter runs FRAME-1 down to 0.
  - After the FRAME-th rising SCLK and its high phase (CLK_DIV cycles), on one edge: CS_n<=1, `ADC`<=shift[11:0], `adc_valid`<=1; go to QUIET.
- CS_n low duration = (2*FRAME+1)*CLK_DIV cycles. With defaults: 132.
- QUIET:
  - CS_n=1, SCLK=1 for 2*CLK_DIV cycles, then IDLE.
  - Minimum conversion spacing = 1+(2*FRAME+1)*CLK_DIV+2*CLK_DIV. With defaults: 141.
  - A smaller SAMPLE_PERIOD is legal; it produces overruns and an effective period rounded up to a multiple of SAMPLE_PERIOD.
- `busy` = (FSM != IDLE), registered.
- `ADC` holds its value between updates; it changes only with `adc_valid` or on reset/abort.

Optional Feature:
- Macro: ADC_LEADBIT_CHECK_EN.
- Defined: at frame end, if any of the LEAD_BITS MSBs of the shift register is 1:
  - `ADC` is not updated and `adc_valid` stays 0.
  - `frame_err` pulses on the edge where `adc_valid` would have pulsed.
  - FSM timing is unchanged.
- Undefined: leading bits are ignored, every frame updates `ADC`, and `frame_err` is constant 0.

Test Plan:
- Defaults; ADC model drives 16'h0ABC MSB first, changing on SCLK falling -> first CS_n fall 200 cycles after reset release; `ADC`=12'hABC with `adc_valid` high 1 cycle; CS_n low exactly 132 cycles; 16 SCLK rising edges.
- Continuous frames 12'h000, 12'hFFF, 12'h800 -> `ADC` matches each; successive CS_n falls exactly 200 cycles apart; `overrun` never asserted.
- `swiptAlive` dropped at SCLK edge 7 of a frame -> next edge CS_n=1, SCLK=1, `ADC`=0, no `adc_valid`; after `swiptAlive` returns, first start after 200 cycles.
- SAMPLE_PERIOD=100 -> `overrun` pulses once per frame (expiry at 100 while busy); frame starts every 200 cycles.
- Macro defined; ADC drives 16'h1ABC -> `frame_err` pulse, `ADC` keeps the previous value, no `adc_valid`. Macro undefined, same stimulus -> `ADC`=12'hABC with `adc_valid`.
- `nrst` asserted mid-SHIFT -> all outputs at reset values next edge; CLK_DIV=2 run still yields the correct word.

Source files
------------

// File: rtl/adc_serial_reader.sv
// rtl/adc_serial_reader.sv - periodic 3-wire serial reader for the external 12-bit ADC
//
// Runs one FRAME = LEAD_BITS+12 bit read frame every SAMPLE_PERIOD clk cycles
// (when idle) and presents the 12 data bits on ADC with a one-cycle adc_valid.
//
// Optional build macro: ADC_LEADBIT_CHECK_EN
//   defined   - frames whose leading bits are not all zero are dropped and
//               reported with a one-cycle frame_err pulse
//   undefined - leading bits are ignored, frame_err is constant 0
//
// Ports:
//   clk         system clock
//   nrst        synchronous active-low reset
//   swiptAlive  link-alive enable; low aborts exactly like reset
//   adc_sdata   serial data from the ADC, MSB first
//   adc_cs_n    ADC chip select, active-low
//   adc_sclk    serial clock, idles high
//   ADC         last good 12-bit sample
//   adc_valid   one-cycle pulse when ADC updates
//   busy        high while a frame is in progress
//   overrun     one-cycle pulse when a period expires while busy
//   frame_err   one-cycle pulse on a leading-bit violation

module adc_serial_reader #(
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 200,
    parameter int LEAD_BITS     = 4
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        swiptAlive,
    input  logic        adc_sdata,
    output logic        adc_cs_n,
    output logic        adc_sclk,
    output logic [11:0] ADC,
    output logic        adc_valid,
    output logic        busy,
    output logic        overrun,
    output logic        frame_err
);

    localparam int FRAME = LEAD_BITS + 12;
`ifdef ADC_LEADBIT_CHECK_EN
    localparam int SHIFT_W = FRAME;
`else
    // Without the check the leading bits fall off the top unobserved.
    localparam int SHIFT_W = 12;
`endif
    localparam int DIV_W = 9;   // holds 2*CLK_DIV-1 for CLK_DIV up to 255
    localparam int BIT_W = $clog2(FRAME + 1);
    localparam int PER_W = 16;

    localparam logic [DIV_W-1:0] DIV_HALF  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_QUIET = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LOAD  = BIT_W'(FRAME - 1);
    localparam logic [PER_W-1:0] PER_LOAD  = PER_W'(SAMPLE_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, QUIET} state_t;

    state_t             state_q, state_n;
    logic [DIV_W-1:0]   div_q, div_n;
    logic [BIT_W-1:0]   bit_q, bit_n;
    logic [PER_W-1:0]   per_q, per_n;
    logic [SHIFT_W-1:0] shift_q, shift_n;
    logic               cs_n_n, sclk_n, valid_n, ovr_n, busy_n;
    logic [11:0]        adc_n;
    logic               expire;
`ifdef ADC_LEADBIT_CHECK_EN
    logic               ferr_n;
`endif

    always_comb begin
        state_n = state_q;
        div_n   = div_q;
        bit_n   = bit_q;
        shift_n = shift_q;
        cs_n_n  = adc_cs_n;
        sclk_n  = adc_sclk;
        adc_n   = ADC;
        valid_n = 1'b0;
`ifdef ADC_LEADBIT_CHECK_EN
        ferr_n  = 1'b0;
`endif
        // Period counter runs regardless of the FSM; a frame in progress
        // turns an expiry into an overrun instead of a start.
        expire = (per_q == '0);
        per_n  = expire ? PER_LOAD : per_q - 1'b1;
        ovr_n  = expire && (state_q != IDLE);

        case (state_q)
            IDLE: begin
                cs_n_n = 1'b1;
                sclk_n = 1'b1;
                if (expire) begin
                    cs_n_n  = 1'b0;
                    div_n   = DIV_HALF;
                    state_n = SETUP;
                end
            end
            SETUP: begin
                if (div_q == '0) begin
                    state_n = SHIFT;
                    sclk_n  = 1'b0;
                    div_n   = DIV_HALF;
                    bit_n   = BIT_LOAD;
                end else begin
                    div_n = div_q - 1'b1;
                end
            end
            SHIFT: begin
                if (div_q != '0) begin
                    div_n = div_q - 1'b1;
                end else begin
                    div_n = DIV_HALF;
                    if (!adc_sclk) begin
                        // Rising SCLK edge: the ADC changed data on the
                        // previous fall, so sdata has been stable CLK_DIV cycles.
                        sclk_n  = 1'b1;
                        shift_n = {shift_q[SHIFT_W-2:0], adc_sdata};
                    end else if (bit_q == '0) begin
                        // End of the last high phase closes the frame.
                        cs_n_n  = 1'b1;
                        div_n   = DIV_QUIET;
                        state_n = QUIET;
`ifdef ADC_LEADBIT_CHECK_EN
                        if (|shift_q[SHIFT_W-1:12]) begin
                            ferr_n = 1'b1;
                        end else begin
                            adc_n   = shift_q[11:0];
                            valid_n = 1'b1;
                        end
`else
                        adc_n   = shift_q[11:0];
                        valid_n = 1'b1;
`endif
                    end else begin
                        sclk_n = 1'b0;
                        bit_n  = bit_q - 1'b1;
                    end
                end
            end
            QUIET: begin
                cs_n_n = 1'b1;
                sclk_n = 1'b1;
                if (div_q == '0) begin
                    state_n = IDLE;
                end else begin
                    div_n = div_q - 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!nrst || !swiptAlive) begin
            state_q   <= IDLE;
            div_q     <= '0;
            bit_q     <= '0;
            per_q     <= PER_LOAD;
            shift_q   <= '0;
            adc_cs_n  <= 1'b1;
            adc_sclk  <= 1'b1;
            ADC       <= '0;
            adc_valid <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state_q   <= state_n;
            div_q     <= div_n;
            bit_q     <= bit_n;
            per_q     <= per_n;
            shift_q   <= shift_n;
            adc_cs_n  <= cs_n_n;
            adc_sclk  <= sclk_n;
            ADC       <= adc_n;
            adc_valid <= valid_n;
            busy      <= busy_n;
            overrun   <= ovr_n;
        end
    end

`ifdef ADC_LEADBIT_CHECK_EN
    always_ff @(posedge clk) begin
        if (!nrst || !swiptAlive) begin
            frame_err <= 1'b0;
        end else begin
            frame_err <= ferr_n;
        end
    end
`else
    assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_adc_serial_reader.sv
// tb/tb_adc_serial_reader.sv - randomized self-checking bench for adc_serial_reader

module tb_adc_serial_reader;

    localparam int NI = 3;
    localparam int FR = 16;
`ifdef ADC_LEADBIT_CHECK_EN
    localparam bit LEAD_CHK = 1'b1;
`else
    localparam bit LEAD_CHK = 1'b0;
`endif

    function automatic int cd_of(input int g);
        return (g == 2) ? 2 : 4;
    endfunction

    function automatic int sp_of(input int g);
        return (g == 1) ? 100 : 200;
    endfunction

    logic clk = 1'b0;
    logic nrst = 1'b0;
    logic swipt = 1'b1;
    int   cyc = 0;
    bit   rst_e = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    logic [15:0] dir_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        rst_e = !nrst || !swipt;
    end

    task automatic finish_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
            if (n_err >= 30) finish_run();
        end
    endtask

    function automatic logic [15:0] rand_word();
        logic [3:0]  lead;
        logic [11:0] data;
        data = 12'($urandom);
        lead = ($urandom_range(3) == 0) ? 4'($urandom) : 4'h0;
        return {lead, data};
    endfunction

    for (genvar g = 0; g < NI; g++) begin : gi
        localparam int CD  = cd_of(g);
        localparam int SP  = sp_of(g);
        localparam int CSL = (2 * FR + 1) * CD;
        localparam int BL  = (2 * FR + 3) * CD;

        logic        sd = 1'b0;
        logic        cs, sclk, valid, busy, ovr, ferr;
        logic [11:0] adc;
        logic [15:0] fw = 16'h0;
        int          bi = 0;

        adc_serial_reader #(
            .CLK_DIV(CD),
            .SAMPLE_PERIOD(SP),
            .LEAD_BITS(4)
        ) u_dut (
            .clk(clk),
            .nrst(nrst),
            .swiptAlive(swipt),
            .adc_sdata(sd),
            .adc_cs_n(cs),
            .adc_sclk(sclk),
            .ADC(adc),
            .adc_valid(valid),
            .busy(busy),
            .overrun(ovr),
            .frame_err(ferr)
        );

        // ADC slave: picks the frame word at CS fall, presents the next bit
        // MSB first on every SCLK falling edge.
        always @(negedge cs) begin
            bi = 0;
            if (g == 0 && dir_q.size() > 0) fw = dir_q.pop_front();
            else fw = rand_word();
        end

        always @(negedge sclk) begin
            if (!cs && bi < FR) begin
                sd = fw[15 - bi];
                bi++;
            end
        end

        // Reference model: frame timing as offsets from the start edge.
        int          r_e = 0;
        int          s_e = -1;
        logic [11:0] e_adc = 12'h0;
        int          lowc = 0;
        int          risec = 0;
        bit          abrt = 1'b0;
        logic        pcs = 1'b1;
        logic        psclk = 1'b1;

        always @(negedge clk) begin
            logic e_cs, e_sclk, e_busy, e_val, e_ov, e_fe;
            int   o;
            e_ov  = 1'b0;
            e_val = 1'b0;
            e_fe  = 1'b0;
            if (rst_e) begin
                r_e   = cyc;
                s_e   = -1;
                e_adc = 12'h0;
                abrt  = 1'b1;
            end else if (cyc > r_e && (cyc - r_e) % SP == 0) begin
                if (s_e >= 0 && (cyc - 1 - s_e) < BL) e_ov = 1'b1;
                else s_e = cyc;
            end
            o      = (s_e >= 0) ? (cyc - s_e) : BL + 1000;
            e_cs   = !(o < CSL);
            e_sclk = !(o >= CD && o < CSL && ((o - CD) / CD) % 2 == 0);
            e_busy = (o < BL);
            if (o == CSL) begin
                if (LEAD_CHK && fw[15:12] != 4'h0) e_fe = 1'b1;
                else begin
                    e_val = 1'b1;
                    e_adc = fw[11:0];
                end
            end
            chk($sformatf("i%0d_ctl{cs,sclk,busy,valid,ovr,ferr}", g),
                {26'h0, cs, sclk, busy, valid, ovr, ferr},
                {26'h0, e_cs, e_sclk, e_busy, e_val, e_ov, e_fe});
            chk($sformatf("i%0d_adc", g), {20'h0, adc}, {20'h0, e_adc});

            // Direct frame measurements: CS low length and SCLK rising count.
            if (pcs && !cs) begin
                lowc  = 0;
                risec = 0;
                abrt  = 1'b0;
            end
            if (!cs) lowc++;
            if (!psclk && sclk) risec++;
            if (!pcs && cs && !abrt) begin
                chk($sformatf("i%0d_cs_low_len", g), lowc, CSL);
                chk($sformatf("i%0d_sclk_rises", g), risec, FR);
            end
            pcs   = cs;
            psclk = sclk;
        end
    end

    task automatic wait_frame_start();
        int k;
        k = 0;
        while (gi[0].cs === 1'b0 && k < 400) begin
            @(negedge clk);
            k++;
        end
        k = 0;
        while (gi[0].cs !== 1'b0 && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk("cs_fall_wait", {31'h0, gi[0].cs}, 32'h0);
    endtask

    task automatic drive_cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        int rk;
        int k;
        logic ps;
        dir_q = '{16'h0ABC, 16'h0000, 16'h0FFF, 16'h0800, 16'h1ABC, 16'h0ABC};

        drive_cycles(4);
        rk   = cyc;
        nrst = 1'b1;

        // First start lands exactly one period after the last reset edge.
        wait_frame_start();
        chk("first_start_delay", cyc - rk, 200);
        k = 0;
        while (gi[0].valid !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("first_word", {20'h0, gi[0].adc}, 32'hABC);

        drive_cycles(1100);

        // Abort on the 7th SCLK edge of a fresh frame.
        wait_frame_start();
        k = 0;
        ps = gi[0].sclk;
        while (k < 7) begin
            @(negedge clk);
            if (gi[0].sclk !== ps) k++;
            ps = gi[0].sclk;
            if (gi[0].cs !== 1'b0) break;
        end
        chk("abort_in_frame", {31'h0, gi[0].cs}, 32'h0);
        drive_cycles(1);
        swipt = 1'b0;
        drive_cycles(1);
        swipt = 1'b1;
        drive_cycles(900);

        // Reset in the middle of SHIFT.
        wait_frame_start();
        repeat (40) @(negedge clk);
        drive_cycles(1);
        nrst = 1'b0;
        drive_cycles(1);
        nrst = 1'b1;

        drive_cycles(3000);
        finish_run();
    end

endmodule
